// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared geometry constants and FSM state encoding for the
//            direct-mapped write-back data cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int TAG_W   = 25;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int LINES   = 8;
    localparam int WORDS   = 4;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
    localparam int BADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module   : dcache_array
// Brief    : Tag / valid / dirty / data storage for an 8-line, 4-word
//            direct-mapped cache. Asynchronous read of the indexed line,
//            synchronous word write (sets dirty) and line fill (clean, valid).
// Revision : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [IDX_W-1:0]   i_index,
    input  wire logic [OFF_W-1:0]   i_word,
    input  wire logic               i_word_we,
    input  wire logic [WORD_W-1:0]  i_wdata,
    input  wire logic               i_fill_we,
    input  wire logic [TAG_W-1:0]   i_fill_tag,
    input  wire logic [BLOCK_W-1:0] i_fill_data,
    output logic                    o_valid,
    output logic                    o_dirty,
    output logic [TAG_W-1:0]        o_tag,
    output logic [BLOCK_W-1:0]      o_line
);

    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [BLOCK_W-1:0] r_data [LINES];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

    // Line status bits: cleared by reset, fill makes a line valid and clean,
    // a word store marks it dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tag and data payload; left uninitialised since valid gates every use.
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_data;
        end else if (i_word_we) begin
            r_data[i_index][i_word*WORD_W +: WORD_W] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped, write-back, write-allocate data cache controller.
//            Zero-wait hits in COMPARE; misses go through optional WRITEBACK
//            of a dirty victim, then ALLOCATE, then complete as a hit.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               proc_read,
    input  wire logic               proc_write,
    input  wire logic [ADDR_W-1:0]  proc_addr,
    input  wire logic [WORD_W-1:0]  proc_wdata,
    output logic [WORD_W-1:0]       proc_rdata,
    output logic                    proc_stall,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [BADDR_W-1:0]      mem_addr,
    output logic [BLOCK_W-1:0]      mem_wdata,
    input  wire logic [BLOCK_W-1:0] mem_rdata,
    input  wire logic               mem_ready
);

    state_t             r_state;
    logic               r_mem_read;
    logic               r_mem_write;

    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_index;
    logic [OFF_W-1:0]   w_word;
    logic               w_valid;
    logic               w_dirty;
    logic [TAG_W-1:0]   w_line_tag;
    logic [BLOCK_W-1:0] w_line;
    logic [WORD_W-1:0]  w_sel_word;
    logic               w_req;
    logic               w_hit;
    logic               w_wr_hit;
    logic               w_rd_hit;
    logic               w_fill;

    assign w_tag   = proc_addr[ADDR_W-1 -: TAG_W];
    assign w_index = proc_addr[OFF_W +: IDX_W];
    assign w_word  = proc_addr[OFF_W-1:0];

    assign w_req    = proc_read | proc_write;
    assign w_hit    = (r_state == ST_COMPARE) && w_req && w_valid && (w_line_tag == w_tag);
    // A simultaneous read+write is a store, so only a pure read returns data.
    assign w_wr_hit = w_hit & proc_write & ~rst;
    assign w_rd_hit = w_hit & ~proc_write & ~rst;
    assign w_fill   = (r_state == ST_ALLOCATE) & mem_ready & ~rst;

    assign w_sel_word = w_line[w_word*WORD_W +: WORD_W];

    dcache_array u_array (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_word      (w_word),
        .i_word_we   (w_wr_hit),
        .i_wdata     (proc_wdata),
        .i_fill_we   (w_fill),
        .i_fill_tag  (w_tag),
        .i_fill_data (mem_rdata),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_line_tag),
        .o_line      (w_line)
    );

    // Controller FSM; memory strobes are registered alongside the state so
    // they are asserted for exactly the cycles spent in each transfer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COMPARE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                ST_COMPARE: begin
                    if (w_req && !w_hit) begin
                        if (w_valid && w_dirty) begin
                            r_state     <= ST_WRITEBACK;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= ST_ALLOCATE;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        r_state     <= ST_ALLOCATE;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        r_state    <= ST_COMPARE;
                        r_mem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_COMPARE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are forced low while reset is held so an abandoned transfer
    // disappears immediately.
    assign mem_read   = r_mem_read & ~rst;
    assign mem_write  = r_mem_write & ~rst;
    assign proc_stall = ~rst & ((r_state != ST_COMPARE) | (w_req & ~w_hit));
    assign proc_rdata = w_rd_hit ? w_sel_word : '0;

    // Memory address/data: victim block during writeback, requested block
    // during allocate, zero otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (r_state == ST_WRITEBACK) begin
                mem_addr  = {w_line_tag, w_index};
                mem_wdata = w_line;
            end else if (r_state == ST_ALLOCATE) begin
                mem_addr  = proc_addr[ADDR_W-1:OFF_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Self-checking bench for dcache_ctrl: directed scenarios followed
//            by random loads/stores against a line-level cache + memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int errors = 0;
    int checks = 0;

    // Reference model: cache line contents and backing memory.
    logic         m_valid [8];
    logic         m_dirty [8];
    logic [24:0]  m_tag   [8];
    logic [127:0] m_data  [8];
    logic [127:0] mem     [logic [27:0]];

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_block(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return {a + 28'h300, 4'h3, a + 28'h200, 4'h2, a + 28'h100, 4'h1, a, 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // One CPU request held until the cache stops stalling; the bench plays
    // memory with the given per-transfer latencies (cycles incl. ready cycle).
    task automatic do_req(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wd, input int lat_wb, input int lat_rd);
        logic [2:0]   idx;
        logic [24:0]  tg;
        int           word;
        logic         hit, dirty_miss, done, wb_seen, rd_seen, excl_bad;
        int           cycles, phase, exp_cycles;
        idx  = addr[4:2];
        tg   = addr[29:5];
        word = int'(addr[1:0]);
        hit        = m_valid[idx] && (m_tag[idx] == tg);
        dirty_miss = !hit && m_valid[idx] && m_dirty[idx];
        exp_cycles = hit ? 1 : (2 + lat_rd + (dirty_miss ? lat_wb : 0));
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        cycles = 0; phase = 0; done = 1'b0;
        wb_seen = 1'b0; rd_seen = 1'b0; excl_bad = 1'b0;
        while (!done && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (mem_read && mem_write) excl_bad = 1'b1;
            if (cycles == 1 && !hit)
                chk("cmp_mem_idle", {mem_read, mem_write}, 2'b00);
            if (!proc_stall) begin
                done = 1'b1;
            end else if (mem_write) begin
                if (!wb_seen) begin
                    wb_seen = 1'b1;
                    chk("wb_addr", mem_addr, {m_tag[idx], idx});
                    chk("wb_data", mem_wdata, m_data[idx]);
                end
                phase++;
                if (phase == lat_wb) begin
                    mem[{m_tag[idx], idx}] = m_data[idx];
                    mem_ready = 1'b1;
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                    phase = 0;
                end
            end else if (mem_read) begin
                if (!rd_seen) begin
                    rd_seen = 1'b1;
                    chk("alloc_addr", mem_addr, addr[29:2]);
                end
                phase++;
                if (phase == lat_rd) begin
                    mem_rdata = mem_block(addr[29:2]);
                    mem_ready = 1'b1;
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    phase = 0;
                end
            end
        end
        chk("req_done", done, 1'b1);
        chk("wb_seen", wb_seen, dirty_miss);
        chk("rd_seen", rd_seen, !hit);
        chk("latency", 128'(cycles), 128'(exp_cycles));
        chk("mem_excl", excl_bad, 1'b0);
        if (!hit) begin
            m_data[idx]  = mem_block(addr[29:2]);
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (rd && !wr) chk("rdata", proc_rdata, m_data[idx][word*32 +: 32]);
        else           chk("rdata_wr_zero", proc_rdata, 32'h0);
        @(posedge clk); #1;
        if (wr) begin
            m_data[idx][word*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    initial begin
        logic [29:0] ra;
        logic        rrd, rboth;
        rst = 1'b1; proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h4;
        proc_wdata = 32'h0; mem_rdata = '0; mem_ready = 1'b0;
        model_reset();
        mem[28'h1] = {32'd4, 32'd3, 32'd2, 32'd1};

        // Reset: every output quiet even with a request present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", proc_stall, 1'b0);
        chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        chk("rst_mem_addr", mem_addr, 28'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_rdata", proc_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; proc_read = 1'b0;
        @(negedge clk);
        chk("idle_stall", proc_stall, 1'b0);
        @(posedge clk); #1;

        // Cold read miss then zero-wait hit on same line.
        do_req(1'b1, 1'b0, 30'h4, 32'h0, 1, 3);
        do_req(1'b1, 1'b0, 30'h5, 32'h0, 1, 1);

        // Store hit, then conflicting read forces writeback of dirty line.
        do_req(1'b0, 1'b1, 30'h4, 32'hDEAD_BEEF, 1, 1);
        do_req(1'b1, 1'b0, 30'h24, 32'h0, 2, 2);
        chk("victim_mem_word0", mem[28'h1][31:0], 32'hDEAD_BEEF);

        // Read+write together is a store; a later read sees it.
        do_req(1'b1, 1'b0, 30'h4, 32'h0, 1, 2);
        do_req(1'b1, 1'b1, 30'h6, 32'h0000_1234, 1, 1);
        do_req(1'b1, 1'b0, 30'h6, 32'h0, 1, 1);

        // Spurious mem_ready with no request is ignored.
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
        #1;
        chk("spur_stall", proc_stall, 1'b0);
        chk("spur_mem_rw", {mem_read, mem_write}, 2'b00);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("spur_stall_after", proc_stall, 1'b0);
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 30'h6, 32'h0, 1, 1);

        // Reset in the middle of an allocate abandons it; line misses again.
        proc_read = 1'b1; proc_addr = 30'h100;
        @(negedge clk);
        chk("ra_cmp_stall", proc_stall, 1'b1);
        @(negedge clk);
        chk("ra_alloc_read", mem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("ra_rst_mem_read", mem_read, 1'b0);
        chk("ra_rst_stall", proc_stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        do_req(1'b1, 1'b0, 30'h100, 32'h0, 1, 2);
        do_req(1'b1, 1'b0, 30'h4, 32'h0, 1, 1);

        // Random loads/stores over a small tag range to mix hits and conflicts.
        for (int n = 0; n < 200; n++) begin
            ra    = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            rrd   = 1'($urandom_range(0, 1));
            rboth = ($urandom_range(0, 7) == 0);
            do_req(rrd | rboth, ~rrd | rboth, ra, $urandom,
                   int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rand_idle_stall", proc_stall, 1'b0);
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port proc_read, input, 1, CPU load request, held until proc_stall low.
REQ-004 SHALL have port proc_write, input, 1, CPU store request, held until proc_stall low.
REQ-005 SHALL have port proc_addr, input, 30, word address: tag [29:5], index [4:2], word offset [1:0].
REQ-006 SHALL have port proc_wdata, input, 32, store data.
REQ-007 SHALL have port proc_rdata, output, 32, load data, valid when proc_stall low and proc_read high.
REQ-008 SHALL have port proc_stall, output, 1, high while a request cannot complete this cycle.
REQ-009 SHALL have port mem_read, output, 1, block fetch request, held until mem_ready.
REQ-010 SHALL have port mem_write, output, 1, block writeback request, held until mem_ready.
REQ-011 SHALL have port mem_addr, output, 28, block address {tag,index}.
REQ-012 SHALL have port mem_wdata, output, 128, writeback block, word 0 in [31:0].
REQ-013 SHALL have port mem_rdata, input, 128, fetched block, sampled when mem_ready high.
REQ-014 SHALL have port mem_ready, input, 1, one-cycle memory completion pulse.

Function
REQ-015 SHALL be direct-mapped, write-back, write-allocate: 8 lines x 4 words, per-line valid, dirty, 25-bit tag.
REQ-016 SHALL use FSM states COMPARE, WRITEBACK, ALLOCATE; reset state COMPARE.
REQ-017 SHALL define hit as valid[index] and tag match while proc_read or proc_write high, in COMPARE.
REQ-018 Read hit SHALL drive proc_stall=0 and proc_rdata=selected word combinationally in the same cycle (zero-wait).
REQ-019 Write hit SHALL drive proc_stall=0 same cycle and, at that edge, write proc_wdata to the selected word and set dirty=1.
REQ-020 Miss with clean or invalid line SHALL go COMPARE->ALLOCATE; miss with valid dirty line SHALL go COMPARE->WRITEBACK.
REQ-021 WRITEBACK SHALL assert mem_write, mem_addr={stored tag,index}, mem_wdata=stored line; on mem_ready go to ALLOCATE.
REQ-022 ALLOCATE SHALL assert mem_read, mem_addr=proc_addr[29:2]; on mem_ready load mem_rdata, set valid=1, dirty=0, tag=proc tag, go COMPARE.
REQ-023 After ALLOCATE, the held request SHALL complete as a hit in the next COMPARE cycle (miss latency = memory cycles + 1).
REQ-024 proc_stall SHALL be 1 in WRITEBACK and ALLOCATE and on a COMPARE miss; 0 when no request is present.
REQ-025 mem_read and mem_write SHALL never be high together; both 0 in COMPARE.
REQ-026 proc_read and proc_write both high SHALL be treated as a write.
REQ-027 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-028 proc_rdata SHALL be 0 when not a read hit.

Reset
REQ-029 On rst high at an edge: state=COMPARE, all valid=0, all dirty=0; data/tag arrays need not be cleared.
REQ-030 During rst: proc_stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
REQ-031 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transfer; mem_read/mem_write low from the next cycle; memory discards it.

Structure
REQ-032 Shared package SHALL hold TAG_W=25, IDX_W=3, LINES=8, WORDS=4, BLOCK_W=128 and the FSM state encoding.
REQ-033 Storage (tag, valid, dirty, data arrays, reset clear of valid/dirty) SHALL be one sub-module dcache_array; FSM and muxing in dcache_ctrl.

Verification
REQ-034 Cold read 0x0000_0004 (index 1), mem_ready after 3 cycles with block {4,3,2,1} -> stall 5 cycles incl. hit cycle low, proc_rdata=1, mem_addr=0x000_0001.
REQ-035 Repeat read 0x0000_0005 -> proc_stall=0 same cycle, proc_rdata=2, no mem_read.
REQ-036 Write 0xDEAD_BEEF to 0x0000_0004 then read 0x0000_0024 (same index, tag 1) -> mem_write with mem_addr=0x000_0001, mem_wdata[31:0]=0xDEADBEEF, then mem_read mem_addr=0x000_0009.
REQ-037 rst asserted during ALLOCATE -> mem_read 0 next cycle; following read of same address misses again.
REQ-038 proc_read and proc_write high on hit to 0x0000_0006 with 0x1234 -> treated as write; subsequent read returns 0x1234.
REQ-039 Spurious mem_ready pulse in COMPARE with no request -> no state or array change, proc_stall=0.
